// File: rtl/ps2_scancode_dec.sv
// Folds PS/2 set-2 bytes (E0/F0/E1 sequences) into one key event each; event registered 1 cycle after the last byte,
// single output register so bytes stall while an event waits. Macro PS2_KEYSTATE_EN adds a pressed-key bitmap.
module ps2_scancode_dec #(
  parameter int TIMEOUT_CYC = 100000,
  parameter int CNT_W       = 17
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [7:0] byte_i,
  input  logic       byte_valid_i,
  output logic       byte_ready_o,
  output logic [7:0] evt_code_o,
  output logic       evt_ext_o,
  output logic       evt_brk_o,
  output logic       evt_valid_o,
  input  logic       evt_ready_i,
  output logic       err_o
`ifdef PS2_KEYSTATE_EN
  ,
  input  logic [8:0] key_idx_i,
  output logic       key_down_o
`endif
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EXT     = 3'd1,
    S_BRK     = 3'd2,
    S_EXT_BRK = 3'd3,
    S_PAUSE   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC > 0 ? TIMEOUT_CYC - 1 : 0);

  state_t           state_q, state_d;
  logic [2:0]       skip_q, skip_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             evt_valid_q, evt_valid_d;
  logic [7:0]       evt_code_q, evt_code_d;
  logic             evt_ext_q, evt_ext_d;
  logic             evt_brk_q, evt_brk_d;
  logic             err_q, err_d;
  logic             byte_acc;
  logic             load;
  logic [7:0]       ld_code;
  logic             ld_ext, ld_brk;

  assign byte_ready_o = en_i && (!evt_valid_q || evt_ready_i);
  assign byte_acc     = byte_valid_i && byte_ready_o;

  always_comb begin
    state_d     = state_q;
    skip_d      = skip_q;
    cnt_d       = cnt_q;
    evt_valid_d = evt_valid_q && !evt_ready_i;
    evt_code_d  = evt_code_q;
    evt_ext_d   = evt_ext_q;
    evt_brk_d   = evt_brk_q;
    err_d       = 1'b0;
    load        = 1'b0;
    ld_code     = byte_i;
    ld_ext      = 1'b0;
    ld_brk      = 1'b0;

    if (byte_acc) begin
      cnt_d = '0;
      unique case (state_q)
        S_IDLE: begin
          case (byte_i)
            8'hE0: state_d = S_EXT;
            8'hF0: state_d = S_BRK;
            8'hE1: begin
              state_d = S_PAUSE;
              skip_d  = 3'd7;
            end
            8'h00, 8'hFF: err_d = 1'b1;
            8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFC: ;
            default: load = 1'b1;
          endcase
        end
        S_EXT: begin
          case (byte_i)
            8'hF0: state_d = S_EXT_BRK;
            8'hE0: err_d = 1'b1;
            8'h12, 8'h7C: state_d = S_IDLE;
            default: begin
              load    = 1'b1;
              ld_ext  = 1'b1;
              state_d = S_IDLE;
            end
          endcase
        end
        S_BRK: begin
          case (byte_i)
            8'hF0: begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end
            8'hE0: begin
              err_d   = 1'b1;
              state_d = S_EXT;
            end
            default: begin
              load    = 1'b1;
              ld_brk  = 1'b1;
              state_d = S_IDLE;
            end
          endcase
        end
        S_EXT_BRK: begin
          case (byte_i)
            8'hE0, 8'hF0: begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end
            8'h12: state_d = S_IDLE;
            default: begin
              load    = 1'b1;
              ld_ext  = 1'b1;
              ld_brk  = 1'b1;
              state_d = S_IDLE;
            end
          endcase
        end
        S_PAUSE: begin
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) begin
            load    = 1'b1;
            ld_code = 8'hE1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE && byte_ready_o && TIMEOUT_CYC != 0) begin
      // Stalled by the consumer does not age the sequence: byte_ready_o gates counting.
      if (cnt_q == TO_LAST) begin
        err_d   = 1'b1;
        state_d = S_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    if (load) begin
      evt_valid_d = 1'b1;
      evt_code_d  = ld_code;
      evt_ext_d   = ld_ext;
      evt_brk_d   = ld_brk;
    end

    if (!en_i) begin
      state_d     = S_IDLE;
      cnt_d       = '0;
      evt_valid_d = 1'b0;
      err_d       = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      skip_q      <= 3'd0;
      cnt_q       <= '0;
      evt_valid_q <= 1'b0;
      evt_code_q  <= 8'h00;
      evt_ext_q   <= 1'b0;
      evt_brk_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      skip_q      <= skip_d;
      cnt_q       <= cnt_d;
      evt_valid_q <= evt_valid_d;
      evt_code_q  <= evt_code_d;
      evt_ext_q   <= evt_ext_d;
      evt_brk_q   <= evt_brk_d;
      err_q       <= err_d;
    end
  end

  assign evt_valid_o = evt_valid_q;
  assign evt_code_o  = evt_code_q;
  assign evt_ext_o   = evt_ext_q;
  assign evt_brk_o   = evt_brk_q;
  assign err_o       = err_q;

`ifdef PS2_KEYSTATE_EN
  logic [511:0] bitmap_q, bitmap_d;
  logic         evt_acc;
  logic         is_pause;

  assign evt_acc  = evt_valid_q && evt_ready_i;
  // {E1,0,0} can only come out of the pause sequence.
  assign is_pause = (evt_code_q == 8'hE1) && !evt_ext_q && !evt_brk_q;

  always_comb begin
    bitmap_d = bitmap_q;
    if (!en_i) begin
      bitmap_d = '0;
    end else if (evt_acc && !is_pause) begin
      bitmap_d[{evt_ext_q, evt_code_q}] = !evt_brk_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bitmap_q <= '0;
    end else begin
      bitmap_q <= bitmap_d;
    end
  end

  assign key_down_o = bitmap_q[key_idx_i];
`endif

endmodule

// File: tb/tb_ps2_scancode_dec.sv
// Directed PS/2 sequences then a random byte stream with random consumer stalls, scored against a
// sequence-level model of the scancode rules.
module tb_ps2_scancode_dec;
  localparam int TO = 50;

  logic       clk = 1'b0;
  logic       rst, en, byte_valid, byte_ready, evt_valid, evt_ready, evt_ext, evt_brk, err;
  logic [7:0] byte_d, evt_code;
`ifdef PS2_KEYSTATE_EN
  logic [8:0] key_idx;
  logic       key_down;
`endif

  int         n_cmp = 0;
  int         n_bad = 0;
  int         err_cnt = 0;
  logic [9:0] got_q[$];
  logic [9:0] exp_q[$];
  bit         m_ext, m_brk;
  int         m_pause = 0;
  int         m_err = 0;
  bit         rnd_on = 1'b0;

  ps2_scancode_dec #(.TIMEOUT_CYC(TO), .CNT_W(7)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en),
    .byte_i(byte_d), .byte_valid_i(byte_valid), .byte_ready_o(byte_ready),
    .evt_code_o(evt_code), .evt_ext_o(evt_ext), .evt_brk_o(evt_brk),
    .evt_valid_o(evt_valid), .evt_ready_i(evt_ready), .err_o(err)
`ifdef PS2_KEYSTATE_EN
    , .key_idx_i(key_idx), .key_down_o(key_down)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    m_ext = 1'b0;
    m_brk = 1'b0;
    m_pause = 0;
  endfunction

  // Sequence-level reading of the scancode rules: prefix flags plus a pause byte budget.
  function automatic void model_feed(input logic [7:0] b);
    if (m_pause > 0) begin
      m_pause--;
      if (m_pause == 0) exp_q.push_back({8'hE1, 2'b00});
      return;
    end
    if (b == 8'hF0) begin
      if (m_brk) begin m_err++; model_clear(); end
      else m_brk = 1'b1;
    end else if (b == 8'hE0) begin
      if (m_ext && m_brk) begin m_err++; model_clear(); end
      else begin
        if (m_ext || m_brk) m_err++;
        m_ext = 1'b1;
        m_brk = 1'b0;
      end
    end else if (!m_ext && !m_brk) begin
      if (b == 8'hE1) m_pause = 7;
      else if (b == 8'h00 || b == 8'hFF) m_err++;
      else if (!(b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFC})) exp_q.push_back({b, 2'b00});
    end else begin
      if (!(m_ext && (b == 8'h12 || (b == 8'h7C && !m_brk)))) exp_q.push_back({b, m_ext, m_brk});
      model_clear();
    end
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (err) err_cnt++;
      if (evt_valid && evt_ready && en) got_q.push_back({evt_code, evt_ext, evt_brk});
      if (byte_valid && byte_ready) model_feed(byte_d);
      if (!en) model_clear();
    end
  end

  always @(posedge clk) begin
    if (rnd_on) begin
      #1;
      evt_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    byte_d = b;
    byte_valid = 1'b1;
    @(negedge clk);
    while (!byte_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!byte_ready) chk("send_ready", 32'(byte_ready), 32'd1);
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic expect_evt(input string tag, input logic [7:0] code, input logic ext, input logic brk);
    int n = 0;
    while (got_q.size() == 0 && n < 30) begin
      tick(1);
      n++;
    end
    chk({tag, "_present"}, 32'(got_q.size() != 0), 32'd1);
    if (got_q.size() != 0) chk(tag, 32'(got_q.pop_front()), 32'({code, ext, brk}));
  endtask

  task automatic expect_quiet(input string tag, input int err_before, input int err_exp);
    tick(4);
    chk({tag, "_noevt"}, 32'(got_q.size()), 32'd0);
    chk({tag, "_err"}, 32'(err_cnt - err_before), 32'(err_exp));
    got_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int e0;
    logic [7:0] b;
    int r;
    rst = 1'b1; en = 1'b1; byte_valid = 1'b0; byte_d = 8'h00; evt_ready = 1'b1;
`ifdef PS2_KEYSTATE_EN
    key_idx = 9'h000;
`endif
    tick(3);
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_code", 32'(evt_code), 32'd0);
    chk("rst_ext", 32'(evt_ext), 32'd0);
    chk("rst_brk", 32'(evt_brk), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    tick(1);

    send(8'h1C);
    chk("lat_valid", 32'(evt_valid), 32'd1);
    expect_evt("make_1c", 8'h1C, 1'b0, 1'b0);
    send(8'hF0); send(8'h1C);
    expect_evt("brk_1c", 8'h1C, 1'b0, 1'b1);
    send(8'hE0); send(8'h75);
    expect_evt("ext_75", 8'h75, 1'b1, 1'b0);
    send(8'hE0); send(8'hF0); send(8'h75);
    expect_evt("extbrk_75", 8'h75, 1'b1, 1'b1);
    send(8'hE0); send(8'h12); send(8'hE0); send(8'h70);
    expect_evt("fake_shift_70", 8'h70, 1'b1, 1'b0);
    expect_quiet("fake_shift", err_cnt, 0);

    e0 = err_cnt;
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    expect_evt("pause", 8'hE1, 1'b0, 1'b0);
    expect_quiet("pause", e0, 0);

    e0 = err_cnt; send(8'h00); expect_quiet("err_00", e0, 1);
    e0 = err_cnt; send(8'hFF); expect_quiet("err_ff", e0, 1);
    e0 = err_cnt; send(8'hAA); send(8'hFA); expect_quiet("silent", e0, 0);
    e0 = err_cnt; send(8'hE0); send(8'hF0); send(8'h12); send(8'hE0); send(8'h7C);
    expect_quiet("fake_drop", e0, 0);
    e0 = err_cnt;
    send(8'hE0); send(8'hE0); send(8'h75);
    expect_evt("ext_e0_75", 8'h75, 1'b1, 1'b0);
    expect_quiet("ext_e0", e0, 1);
    e0 = err_cnt;
    send(8'hF0); send(8'hE0); send(8'h75);
    expect_evt("brk_e0_75", 8'h75, 1'b1, 1'b0);
    expect_quiet("brk_e0", e0, 1);

    evt_ready = 1'b0;
    send(8'h1C);
    chk("bp_valid", 32'(evt_valid), 32'd1);
    byte_d = 8'h32; byte_valid = 1'b1;
    tick(3);
    chk("bp_ready_low", 32'(byte_ready), 32'd0);
    chk("bp_hold_code", 32'(evt_code), 32'h1C);
    evt_ready = 1'b1;
    send(8'h32); send(8'h21);
    expect_evt("bp_1", 8'h1C, 1'b0, 1'b0);
    expect_evt("bp_2", 8'h32, 1'b0, 1'b0);
    expect_evt("bp_3", 8'h21, 1'b0, 1'b0);

    e0 = err_cnt;
    send(8'hE0);
    tick(TO - 1);
    chk("to_not_early", 32'(err_cnt - e0), 32'd0);
    tick(4);
    chk("to_pulse", 32'(err_cnt - e0), 32'd1);
    send(8'h1C);
    expect_evt("to_next", 8'h1C, 1'b0, 1'b0);

    e0 = err_cnt;
    send(8'hE0);
    en = 1'b0;
    tick(1);
    chk("en_low_ready", 32'(byte_ready), 32'd0);
    en = 1'b1;
    send(8'h75);
    expect_evt("en_flush", 8'h75, 1'b0, 1'b0);
    evt_ready = 1'b0;
    send(8'h1C);
    en = 1'b0;
    tick(1);
    chk("en_drop_valid", 32'(evt_valid), 32'd0);
    en = 1'b1; evt_ready = 1'b1;
    expect_quiet("en_drop", e0, 0);

`ifdef PS2_KEYSTATE_EN
    send(8'hE0); send(8'h75);
    expect_evt("ks_make", 8'h75, 1'b1, 1'b0);
    key_idx = 9'h175; #1;
    chk("ks_down", 32'(key_down), 32'd1);
    send(8'hE0); send(8'hF0); send(8'h75);
    expect_evt("ks_brk", 8'h75, 1'b1, 1'b1);
    #1 chk("ks_up", 32'(key_down), 32'd0);
    send(8'h1C);
    expect_evt("ks_make_1c", 8'h1C, 1'b0, 1'b0);
    key_idx = 9'h01C; #1;
    chk("ks_1c_down", 32'(key_down), 32'd1);
    en = 1'b0; tick(1); en = 1'b1; #1;
    chk("ks_clear", 32'(key_down), 32'd0);
`endif

    en = 1'b0; tick(1); en = 1'b1;
    model_clear();
    exp_q.delete(); got_q.delete();
    m_err = 0;
    e0 = err_cnt;
    rnd_on = 1'b1;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 15);
      if (r < 3) b = 8'hE0;
      else if (r < 5) b = 8'hF0;
      else if (r == 5) b = 8'hE1;
      else if (r == 6) begin
        case ($urandom_range(0, 4))
          0: b = 8'h00;
          1: b = 8'hFF;
          2: b = 8'hAA;
          3: b = 8'h12;
          default: b = 8'h7C;
        endcase
      end else b = 8'($urandom_range(0, 255));
      tick($urandom_range(0, 2));
      send(b);
    end
    rnd_on = 1'b0;
    @(posedge clk); #2;
    evt_ready = 1'b1;
    tick(20);
    chk("rnd_count", 32'(got_q.size()), 32'(exp_q.size()));
    while (got_q.size() != 0 && exp_q.size() != 0)
      chk("rnd_evt", 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    chk("rnd_err", 32'(err_cnt - e0), 32'(m_err));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
